inst_fetch_queue: RTL

//  Parametrised next-generation fetcher. Runs sequentially ahead of decode and prefetches into a DEPTH-entry queue of {addr, inst} pairs.

---
 rtl/inst_fetch_queue_pkg.sv | 18 +
 rtl/inst_fetch_queue_fetch_fifo.sv | 58 +++++
 rtl/inst_fetch_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue_pkg
// Brief    : Shared constants and FSM encoding for the instruction fetch queue
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_queue_pkg;

    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_WAIT = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_e;

endpackage : inst_fetch_queue_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Generic synchronous FIFO with clear, registered storage and count
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    // A pop on an empty queue is silently dropped.
    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : Sequential prefetcher between InstCache and Decoder with flush
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                    QUEUE_DEPTH = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    localparam int                   CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_handle,
    input  logic                  inst_ready_in,
    input  logic [INST_WIDTH-1:0] inst_in,
    output logic                  inst_valid_out,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_addr_out,
    input  logic                  dec_accept,
    input  logic                  dec_redirect,
    input  logic [ADDR_WIDTH-1:0] dec_redirect_addr,
    input  logic                  rob_clear,
    input  logic [ADDR_WIDTH-1:0] rob_rst_addr,
    output logic [CNT_W-1:0]      queue_count
);

    localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH;

    fq_state_e             state;
    fq_state_e             state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] issued_addr;
    logic                  flush;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  clear;
    logic [ENTRY_W-1:0]    head_data;

    assign flush = rob_clear || dec_redirect;

    assign inst_req = rdy_in && (state == FQ_IDLE)
                   && (queue_count < CNT_W'(QUEUE_DEPTH)) && !flush;
    assign inst_addr = fetch_pc;
    assign issue     = inst_req && inst_handle;

    // A response landing in the same cycle as a flush belongs to the old stream.
    assign push  = rdy_in && inst_ready_in && (state == FQ_WAIT) && !flush;
    assign clear = rdy_in && flush;

    assign inst_valid_out = rdy_in && (queue_count != '0) && !flush;
    assign pop            = inst_valid_out && dec_accept;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= FQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A DROP that sees its response returns to IDLE so the stale reply cannot stall fetch.
    always_comb begin
        state_next = state;
        if (rdy_in) begin
            case (state)
                FQ_IDLE: if (issue)         state_next = FQ_WAIT;
                FQ_WAIT: if (inst_ready_in) state_next = FQ_IDLE;
                         else if (flush)    state_next = FQ_DROP;
                FQ_DROP: if (inst_ready_in) state_next = FQ_IDLE;
                default:                    state_next = FQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fetch_pc    <= RESET_PC;
            issued_addr <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                fetch_pc <= rob_rst_addr;
            end else if (dec_redirect) begin
                fetch_pc <= dec_redirect_addr;
            end else if (issue) begin
                issued_addr <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_WIDTH'(INST_BYTES);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data ({issued_addr, inst_in}),
        .head_data (head_data),
        .count     (queue_count)
    );

    assign inst_addr_out = head_data[ENTRY_W-1:INST_WIDTH];
    assign inst_out      = head_data[INST_WIDTH-1:0];

endmodule : inst_fetch_queue
`default_nettype wire
